mem_stage_dmem: RTL
===================

// Module: mem_stage_dmem
// PURPOSE
//  MEM stage of the 5-stage RISC-V pipeline; sits between the MEM pipeline register and WB.
//  Performs data memory loads/stores (byte/half/word, RV32I), with configurable wait states.
//  Stalls upstream while an access is pending. Registers the results into the WB-stage outputs.
// PARAMETERS
//  ADDR_W       10  word-address width; DEPTH = 2**ADDR_W 32-bit words
//  WAIT_CYCLES  0   extra cycles per memory access (0..15); 0 = single-cycle access
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous reset, active-high
//  MEM_mem_en    in   1   memory access request (load or store)
//  MEM_mem_wr    in   1   1 = store, 0 = load (valid when MEM_mem_en)
//  MEM_funct3    in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  MEM_wr_en     in   1   instruction writes rd
//  MEM_rd_sel    in   5   destination register
//  MEM_alu_val   in   32  ALU result; also the byte address for memory ops
//  MEM_rs2_val   in   32  store data
//  mem_stall     out  1   combinational; upstream holds all MEM_* inputs while high
//  MEM_err       out  1   registered 1-cycle pulse: misaligned or illegal funct3
//  WB_wr_en      out  1   registered write enable to the register file
//  WB_rd_sel     out  5   registered destination register
//  WB_wb_val     out  32  registered writeback value (load data or ALU value)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; WB_wr_en=0, WB_rd_sel=0, WB_wb_val=0, MEM_err=0. Array not cleared.
//  Memory: word index = MEM_alu_val[ADDR_W+1:2]; little-endian byte lanes; upper address bits ignored.
//  Non-memory op (MEM_mem_en=0): next edge WB_wr_en<=MEM_wr_en, WB_rd_sel<=MEM_rd_sel,
//    WB_wb_val<=MEM_alu_val. No stall. rd=0 is passed through unchanged.
//  Error: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 outside the legal set for the op
//    (stores: 000/001/010 only). No array write, no stall. Next edge: MEM_err=1, WB_wr_en=0, WB_wb_val=0.
//  Load data: B/H sign-extend, BU/HU zero-extend the selected lane.
//    Store: SB/SH write only the addressed lanes; other bytes are preserved.
//  Store: WB_wr_en<=0 on completion regardless of MEM_wr_en.
//  FSM states IDLE and WAIT; cnt is 4-bit. Legal request = MEM_mem_en and no error.
//   WAIT_CYCLES=0: the access completes at the next edge in IDLE; mem_stall stays 0.
//   WAIT_CYCLES=N>0:
//    IDLE + legal request: mem_stall=1; edge -> WAIT, cnt<=N-1, WB_wr_en<=0 (bubble).
//    WAIT, cnt!=0: mem_stall=1, cnt<=cnt-1, WB_wr_en<=0.
//    WAIT, cnt==0: mem_stall=0; at that edge the access executes,
//      WB_* capture the result, and the FSM returns to IDLE.
//    Net timing: mem_stall high for exactly N cycles; result in WB N+1 edges after the request.
//    Exactly one array write per store.
//  Load-after-store to the same word returns the new data (the store is committed at its completion edge).
//  rst during WAIT: abort; no array write; FSM returns to IDLE with reset values on all outputs.
//  Inputs are sampled only at the completion edge; changes while mem_stall=1 are a protocol violation.
// TESTING
//  T1 WAIT=0: SW 0xDEADBEEF@0x10, then LW@0x10 -> WB_wb_val=0xDEADBEEF and WB_wr_en=1 one edge later;
//     mem_stall stays 0.
//  T2 SB 0x80@0x13; LB@0x13 -> 0xFFFFFF80; LBU@0x13 -> 0x00000080;
//     LW@0x10 -> 0x80ADBEEF; LH@0x12 -> 0xFFFF80AD.
//  T3 WAIT=3: LW@0x10 -> mem_stall=1 for exactly 3 cycles; WB valid on 4th edge; stores write once.
//  T4 LH@0x11 and SW@0x12 -> MEM_err 1-cycle pulse, WB_wr_en=0, memory unchanged, no stall.
//  T5 WAIT=3: SW 0x1@0x20; rst asserted on 2nd stall cycle
//     -> word@0x20 keeps its old value, FSM IDLE, all outputs 0.
//  T6 ALU op wr_en=1, rd=5, val=0x1234 -> next edge WB_wr_en=1, WB_rd_sel=5, WB_wb_val=0x1234.

Source files
------------

// File: rtl/mem_stage_dmem.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem
// MEM stage of the 5-stage RV32I pipeline. Sits between the MEM pipeline
// register and WB. It performs byte/half/word loads and stores into a local
// data memory, inserts WAIT_CYCLES extra cycles per legal access (stalling
// upstream meanwhile), and registers the result into the WB-stage outputs.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   MEM_mem_en    memory access request (load or store)
//   MEM_mem_wr    1 = store, 0 = load
//   MEM_funct3    size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   MEM_wr_en     instruction writes rd
//   MEM_rd_sel    destination register
//   MEM_alu_val   ALU result / byte address
//   MEM_rs2_val   store data
//   mem_stall     combinational stall to upstream
//   MEM_err       registered 1-cycle pulse on misaligned / illegal funct3
//   WB_wr_en      registered register-file write enable
//   WB_rd_sel     registered destination register
//   WB_wb_val     registered writeback value
// ---------------------------------------------------------------------------
module mem_stage_dmem #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_mem_en,
   input  logic        MEM_mem_wr,
   input  logic [2:0]  MEM_funct3,
   input  logic        MEM_wr_en,
   input  logic [4:0]  MEM_rd_sel,
   input  logic [31:0] MEM_alu_val,
   input  logic [31:0] MEM_rs2_val,
   output logic        mem_stall,
   output logic        MEM_err,
   output logic        WB_wr_en,
   output logic [4:0]  WB_rd_sel,
   output logic [31:0] WB_wb_val
);

   // state  | meaning
   // S_IDLE | ready; completes immediately when WAIT_CYCLES=0, else starts a wait
   // S_WAIT | access pending; cnt_q counts remaining stall cycles down to 0

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        complete;

   logic [31:0] mem_q [DEPTH];

   logic              f3_legal;
   logic              misalign;
   logic              acc_err;
   logic              legal_req;
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       rd_word;
   logic [31:0]       lane_sh;
   logic [31:0]       load_val;
   logic [3:0]        byte_en;
   logic [31:0]       st_data;
   logic [31:0]       merged;
   logic              unused_addr_hi;

   // ---------------- access decode ----------------
   always_comb begin
      f3_legal = 1'b0;
      case (MEM_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = ~MEM_mem_wr;
         default:                f3_legal = 1'b0;
      endcase

      misalign = 1'b0;
      case (MEM_funct3[1:0])
         2'b01:   misalign = MEM_alu_val[0];
         2'b10:   misalign = |MEM_alu_val[1:0];
         default: misalign = 1'b0;
      endcase
   end

   assign acc_err   = MEM_mem_en & (~f3_legal | misalign);
   assign legal_req = MEM_mem_en & ~acc_err;

   // Upper address bits beyond the array are intentionally ignored.
   assign word_idx       = MEM_alu_val[ADDR_W+1:2];
   assign unused_addr_hi = ^MEM_alu_val[31:ADDR_W+2];
   assign rd_word        = mem_q[word_idx];

   // ---------------- load lane extraction ----------------
   assign lane_sh = rd_word >> {MEM_alu_val[1:0], 3'b000};

   always_comb begin
      load_val = rd_word;
      case (MEM_funct3[1:0])
         2'b00: load_val = MEM_funct3[2] ? {24'd0, lane_sh[7:0]}
                                         : {{24{lane_sh[7]}}, lane_sh[7:0]};
         2'b01: load_val = MEM_funct3[2] ? {16'd0, lane_sh[15:0]}
                                         : {{16{lane_sh[15]}}, lane_sh[15:0]};
         default: load_val = rd_word;
      endcase
   end

   // ---------------- store merge ----------------
   // Read-modify-write of the addressed word so unaddressed lanes survive.
   always_comb begin
      byte_en = 4'b1111;
      st_data = MEM_rs2_val;
      case (MEM_funct3[1:0])
         2'b00: begin
            byte_en = 4'b0001 << MEM_alu_val[1:0];
            st_data = {4{MEM_rs2_val[7:0]}};
         end
         2'b01: begin
            byte_en = MEM_alu_val[1] ? 4'b1100 : 4'b0011;
            st_data = {2{MEM_rs2_val[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            st_data = MEM_rs2_val;
         end
      endcase

      merged = rd_word;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) merged[8*i +: 8] = st_data[8*i +: 8];
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if ((WAIT_CYCLES != 0) && legal_req) begin
               state_d = S_WAIT;
               cnt_d   = WAIT_M1;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // complete marks the edge at which the inputs are sampled and WB updated.
   always_comb begin
      mem_stall = 1'b0;
      complete  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((WAIT_CYCLES != 0) && legal_req) mem_stall = 1'b1;
            else                                 complete  = 1'b1;
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) mem_stall = 1'b1;
            else               complete  = 1'b1;
         end
         default: begin
            mem_stall = 1'b0;
            complete  = 1'b0;
         end
      endcase
   end

   // ---------------- WB registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         WB_wr_en  <= 1'b0;
         WB_rd_sel <= 5'd0;
         WB_wb_val <= 32'd0;
         MEM_err   <= 1'b0;
      end else if (complete) begin
         WB_rd_sel <= MEM_rd_sel;
         if (!MEM_mem_en) begin
            WB_wr_en  <= MEM_wr_en;
            WB_wb_val <= MEM_alu_val;
            MEM_err   <= 1'b0;
         end else if (acc_err) begin
            WB_wr_en  <= 1'b0;
            WB_wb_val <= 32'd0;
            MEM_err   <= 1'b1;
         end else if (MEM_mem_wr) begin
            WB_wr_en  <= 1'b0;
            WB_wb_val <= MEM_alu_val;
            MEM_err   <= 1'b0;
         end else begin
            WB_wr_en  <= MEM_wr_en;
            WB_wb_val <= load_val;
            MEM_err   <= 1'b0;
         end
      end else begin
         // bubble while the access is pending
         WB_wr_en <= 1'b0;
         MEM_err  <= 1'b0;
      end
   end

   // ---------------- data array ----------------
   // Not reset; a reset mid-access suppresses the pending write.
   always_ff @(posedge clk) begin
      if (!rst && complete && legal_req && MEM_mem_wr) begin
         mem_q[word_idx] <= merged;
      end
   end

endmodule
